kbd_uart_fifo: RTL

Parametrised keyboard-link receiver: oversampling UART receiver, inter-byte idle detector and first-word-fall-through byte FIFO in one block. It replaces the fixed 12 MHz / 38400-baud, unbuffered receive path in front of the USB-key translator. Each byte carries a start-of-packet tag, so downstream parsers can resynchronise on CH9350 packets. It also reports sticky framing and overrun errors.

---
 rtl/kbd_pkg.sv | 22 ++
 rtl/kbd_fifo_fwft.sv | 51 +++++
 rtl/kbd_uart_fifo.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
// Shared constants, state encoding and baud math for the keyboard-link receiver.
package kbd_pkg;

  localparam int CH9350_CLK_HZ = 12000000;
  localparam int CH9350_BAUD   = 38400;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  // Clocks per oversample tick; clamped to 1 so a too-fast baud still builds.
  function automatic int calc_prescale(input int clk_hz, input int baud, input int oversample);
    int p;
    p = clk_hz / (baud * oversample);
    return (p < 1) ? 1 : p;
  endfunction

endpackage

// File: rtl/kbd_fifo_fwft.sv
// First-word-fall-through FIFO; head entry is visible whenever empty is low.
module kbd_fifo_fwft #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             wr_en, rd_en;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign wr_en    = push && (!full || pop);
  assign rd_en    = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kbd_uart_fifo.sv
// Oversampling UART receiver with idle/packet-boundary detection feeding a FWFT byte FIFO.
module kbd_uart_fifo
  import kbd_pkg::*;
#(
  parameter int CLK_HZ     = CH9350_CLK_HZ,
  parameter int BAUD       = CH9350_BAUD,
  parameter int OVERSAMPLE = 8,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int IDLE_BITS  = 20
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_rxd,
  input  logic                          i_data_ready,
  output logic                          o_data_valid,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic                          o_data_sop,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_idle,
  output logic                          o_overrun,
  output logic                          o_frame_err,
  input  logic                          i_clr_err
);

  localparam int PRESCALE = calc_prescale(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int PS_W     = $clog2(PRESCALE + 1);
  localparam int OS_W     = $clog2(OVERSAMPLE);
  localparam int BIT_W    = $clog2(DATA_WIDTH + 1);
  localparam int ID_W     = $clog2(IDLE_BITS + 1);

  localparam logic [PS_W-1:0]  PS_MAX  = PS_W'(PRESCALE - 1);
  localparam logic [OS_W-1:0]  OS_MAX  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_WIDTH - 1);
  localparam logic [ID_W-1:0]  ID_MAX  = ID_W'(IDLE_BITS);

  rx_state_t             state;
  logic                  rx_meta, rx_s, rx_d;
  logic [PS_W-1:0]       ps_cnt;
  logic [OS_W-1:0]       os_cnt, idle_sub;
  logic [BIT_W-1:0]      bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic [ID_W-1:0]       idle_cnt;
  logic                  sop_pending;
  logic                  tick, start_edge, os_last;
  logic                  push, frame_set, pop, fifo_full, fifo_empty;

  assign tick       = (ps_cnt == PS_MAX);
  assign start_edge = (state == ST_IDLE) && rx_d && !rx_s;
  assign os_last    = (os_cnt == OS_MAX);
  assign push       = (state == ST_STOP) && tick && os_last && rx_s;
  assign frame_set  = (state == ST_STOP) && tick && os_last && !rx_s;
  assign pop        = o_data_valid && i_data_ready;
  assign o_idle     = (idle_cnt == ID_MAX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= i_rxd;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  // Restarting the prescaler on the start edge aligns samples to the bit centre.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                ps_cnt <= '0;
    else if (start_edge || tick) ps_cnt <= '0;
    else                         ps_cnt <= ps_cnt + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      os_cnt  <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start_edge) begin
          state  <= ST_START;
          os_cnt <= '0;
        end
        ST_START: if (tick) begin
          if (os_cnt == OS_HALF) begin
            state   <= rx_s ? ST_IDLE : ST_DATA;
            os_cnt  <= '0;
            bit_idx <= '0;
          end else os_cnt <= os_cnt + 1'b1;
        end
        ST_DATA: if (tick) begin
          if (os_last) begin
            os_cnt  <= '0;
            shreg   <= {rx_s, shreg[DATA_WIDTH-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == BIT_MAX) state <= ST_STOP;
          end else os_cnt <= os_cnt + 1'b1;
        end
        ST_STOP: if (tick) begin
          if (os_last) begin
            os_cnt <= '0;
            state  <= rx_s ? ST_IDLE : ST_BREAK;
          end else os_cnt <= os_cnt + 1'b1;
        end
        ST_BREAK: if (tick) begin
          if (!rx_s)        os_cnt <= '0;
          else if (os_last) state  <= ST_IDLE;
          else              os_cnt <= os_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Idle timer runs in whole bit-times and saturates at the packet-gap threshold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idle_cnt <= '0;
      idle_sub <= '0;
    end else if (state != ST_IDLE || !rx_s) begin
      idle_cnt <= '0;
      idle_sub <= '0;
    end else if (tick && !o_idle) begin
      if (idle_sub == OS_MAX) begin
        idle_sub <= '0;
        idle_cnt <= idle_cnt + 1'b1;
      end else idle_sub <= idle_sub + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sop_pending <= 1'b1;
      o_overrun   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      if (push)        sop_pending <= 1'b0;
      else if (o_idle) sop_pending <= 1'b1;
      o_overrun   <= (push && fifo_full && !pop) || (o_overrun && !i_clr_err);
      o_frame_err <= frame_set || (o_frame_err && !i_clr_err);
    end
  end

  kbd_fifo_fwft #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (push),
    .push_data ({sop_pending, shreg}),
    .pop       (pop),
    .pop_data  ({o_data_sop, o_data}),
    .count     (o_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign o_data_valid = !fifo_empty;

endmodule
